mult_share_ctrl: RTL and testbench

//  Shares one 32x32 signed sequential shift/add multiplier core among NREQ requesters.

---
 rtl/mult_share_pkg.sv | 15 +
 rtl/mult_share_pick.sv | 40 ++++
 rtl/mult_share_ctrl.sv | 100 ++++++++++
 tb/tb_mult_share_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAPT,
        RESP
    } state_t;

    localparam int MULT_W  = 32;
    localparam int PROD_W  = 64;
    localparam int RSP_LAT = 35;

endpackage

// File: rtl/mult_share_pick.sv
// Combinational request picker: fixed priority by default, round-robin from ptr
// when MULT_SHARE_RR_EN is defined.
module mult_share_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
`ifdef MULT_SHARE_RR_EN
    input  logic [IDW-1:0]  ptr,
`endif
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic        found;
    int unsigned slot;
    logic [IDW-1:0] slot_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef MULT_SHARE_RR_EN
            slot = (32'(ptr) + k) % NREQ;
`else
            slot = k;
`endif
            slot_idx = IDW'(slot);
            if (!found && req[slot_idx]) begin
                found           = 1'b1;
                grant[slot_idx] = 1'b1;
                idx             = slot_idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential signed multiplier core among NREQ requesters.
// Define MULT_SHARE_RR_EN for round-robin arbitration (fixed priority otherwise).
module mult_share_ctrl #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_mlier,
    input  logic [NREQ*32-1:0] req_mcand,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [63:0]        rsp_prodt,
    output logic               busy,
    output logic               m_start,
    output logic [31:0]        m_mlier,
    output logic [31:0]        m_mcand,
    input  logic [63:0]        m_prodt,
    input  logic               m_valid
);
    import mult_share_pkg::*;

    state_t         state;
    logic [IDW-1:0] win_idx;
    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  pick_idx;

`ifdef MULT_SHARE_RR_EN
    logic [IDW-1:0] ptr;
`endif

    mult_share_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
`ifdef MULT_SHARE_RR_EN
        .ptr   (ptr),
`endif
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            win_idx   <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_prodt <= '0;
            busy      <= 1'b0;
            m_start   <= 1'b0;
            m_mlier   <= '0;
            m_mcand   <= '0;
`ifdef MULT_SHARE_RR_EN
            ptr       <= '0;
`endif
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready <= pick_oh;
                        win_idx   <= pick_idx;
                        m_mlier   <= req_mlier[pick_idx*MULT_W +: MULT_W];
                        m_mcand   <= req_mcand[pick_idx*MULT_W +: MULT_W];
                        m_start   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
`ifdef MULT_SHARE_RR_EN
                        ptr       <= (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);
`endif
                    end
                end
                RUN: begin
                    if (m_valid) state <= CAPT;
                end
                // Start stays high through CAPT so the core commits its final
                // sign-adjusted product before we sample it.
                CAPT: begin
                    rsp_prodt <= m_prodt;
                    m_start   <= 1'b0;
                    rsp_valid <= NREQ'(1) << win_idx;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[win_idx]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a behavioural multiplier core
// and a scoreboard of expected products; honours MULT_SHARE_RR_EN.
module tb_mult_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_mlier = '0;
    logic [NREQ*32-1:0] req_mcand = '0;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready = '0;
    logic [63:0]        rsp_prodt;
    logic               busy;
    logic               m_start;
    logic [31:0]        m_mlier;
    logic [31:0]        m_mcand;
    logic [63:0]        m_prodt;
    logic               m_valid;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          idx;
        logic [63:0] prod;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    mult_share_ctrl #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mlier (req_mlier),
        .req_mcand (req_mcand),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prodt (rsp_prodt),
        .busy      (busy),
        .m_start   (m_start),
        .m_mlier   (m_mlier),
        .m_mcand   (m_mcand),
        .m_prodt   (m_prodt),
        .m_valid   (m_valid)
    );

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb_;
        sa  = $signed({{32{a[31]}}, a});
        sb_ = $signed({{32{b[31]}}, b});
        return sa * sb_;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        if (sb.size() == 0) begin
            e.idx  = -1;
            e.prod = 'x;
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Core model: done pulse after 33 start-high edges, final product one edge later.
    int core_cnt = 0;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            core_cnt <= 0;
            m_valid  <= 1'b0;
            m_prodt  <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_start) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == 32) begin
                    m_valid <= 1'b1;
                    m_prodt <= 64'hBAD0_BAD0_BAD0_BAD0;
                end
                if (core_cnt == 33) m_prodt <= smul(m_mlier, m_mcand);
            end else begin
                core_cnt <= 0;
            end
        end
    end

    // Start-pulse shape monitor: last high run length and short low gaps.
    int   lo_run = 99;
    int   hi_run = 0;
    int   last_hi = 0;
    int   gap_bad = 0;
    logic prev_start = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            lo_run     <= 99;
            hi_run     <= 0;
            prev_start <= 1'b0;
        end else begin
            if (m_start) begin
                if (!prev_start && lo_run < 2) gap_bad <= gap_bad + 1;
                hi_run <= hi_run + 1;
                lo_run <= 0;
            end else begin
                if (prev_start) last_hi <= hi_run;
                hi_run <= 0;
                if (lo_run < 99) lo_run <= lo_run + 1;
            end
            prev_start <= m_start;
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic request(input int idx, input logic [31:0] a, input logic [31:0] b, output bit ok);
        req_mlier[idx*32 +: 32] = a;
        req_mcand[idx*32 +: 32] = b;
        req_valid[idx] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (req_ready[idx] === 1'b1) ok = 1'b1;
        end
        req_valid[idx] = 1'b0;
        if (ok) sb.push_back('{idx, smul(a, b)});
    endtask

    task automatic await_rsp(output int cyc, output logic [NREQ-1:0] rv, output logic [63:0] prod);
        cyc = 0;
        while (rsp_valid === '0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        rv   = rsp_valid;
        prod = rsp_prodt;
    endtask

    task automatic ack(input int idx);
        rsp_ready[idx] = 1'b1;
        @(negedge clock);
        rsp_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({req_ready, rsp_valid, busy, m_start} !== '0)
            $display("FAIL reset_ctl: got %b required 0", {req_ready, rsp_valid, busy, m_start});
        else passes++;
        checks++;
        if (rsp_prodt !== '0) $display("FAIL reset_prodt: got %h required 0", rsp_prodt);
        else passes++;
        checks++;
        if ({m_mlier, m_mcand} !== '0) $display("FAIL reset_ops: got %h required 0", {m_mlier, m_mcand});
        else passes++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        bit ok;
        int cyc;
        logic [NREQ-1:0] rv;
        logic [63:0] prod;
        exp_t e;
        request(0, 32'd7, -32'sd3, ok);
        checks++;
        if (!ok || req_ready !== 4'b0001) $display("FAIL single_accept: got ok=%0d ready=%b required 1 0001", ok, req_ready);
        else passes++;
        checks++;
        if ({busy, m_start, m_mlier, m_mcand} !== {1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD})
            $display("FAIL single_core_drive: got %b %b %h %h", busy, m_start, m_mlier, m_mcand);
        else passes++;
        await_rsp(cyc, rv, prod);
        e = pop_exp();
        checks++;
        if (cyc !== 35) $display("FAIL single_latency: got %0d required 35", cyc);
        else passes++;
        checks++;
        if (rv !== 4'b0001) $display("FAIL single_rsp_valid: got %b required 0001", rv);
        else passes++;
        checks++;
        if (prod !== 64'hFFFF_FFFF_FFFF_FFEB || prod !== e.prod)
            $display("FAIL single_prodt: got %h required FFFFFFFFFFFFFFEB", prod);
        else passes++;
        ack(0);
        checks++;
        if ({rsp_valid, busy} !== '0) $display("FAIL single_release: got %b required 0", {rsp_valid, busy});
        else passes++;
        checks++;
        if (last_hi !== 35) $display("FAIL single_start_len: got %0d required 35", last_hi);
        else passes++;
    endtask

    task automatic test_corner();
        bit ok;
        int cyc;
        logic [NREQ-1:0] rv;
        logic [63:0] prod;
        exp_t e;
        request(0, 32'h8000_0000, 32'h8000_0000, ok);
        await_rsp(cyc, rv, prod);
        e = pop_exp();
        checks++;
        if (!ok || prod !== 64'h4000_0000_0000_0000 || prod !== e.prod)
            $display("FAIL corner_minmin: got %h required 4000000000000000", prod);
        else passes++;
        ack(0);
        request(1, 32'd0, -32'sd5, ok);
        await_rsp(cyc, rv, prod);
        e = pop_exp();
        checks++;
        if (!ok || rv !== 4'b0010 || prod !== 64'd0 || e.prod !== 64'd0)
            $display("FAIL corner_zero: got valid=%b prodt=%h required 0010 0", rv, prod);
        else passes++;
        ack(1);
    endtask

    task automatic test_arbitration();
`ifdef MULT_SHARE_RR_EN
        int seq[5] = '{0, 1, 2, 3, 0};
        int nops = 5;
`else
        int seq[5] = '{0, 0, 0, 0, 0};
        int nops = 3;
`endif
        int cyc;
        int w;
        logic [NREQ-1:0] got;
        logic [NREQ-1:0] rv;
        logic [63:0] prod;
        exp_t e;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_mlier[i*32 +: 32] = 32'(i + 2);
            req_mcand[i*32 +: 32] = -32'(3 * (i + 1));
        end
        req_valid = '1;
        for (int n = 0; n < nops; n++) begin
            got = '0;
            for (int t = 0; t < 200 && got === '0; t++) begin
                @(negedge clock);
                got = req_ready;
            end
            checks++;
            if (got !== onehot(seq[n])) $display("FAIL arb_grant%0d: got %b required %b", n, got, onehot(seq[n]));
            else passes++;
            w = 0;
            for (int i = 0; i < NREQ; i++) if (got[i]) w = i;
            sb.push_back('{w, smul(32'(w + 2), -32'(3 * (w + 1)))});
            await_rsp(cyc, rv, prod);
            e = pop_exp();
            checks++;
            if (rv !== got || prod !== e.prod)
                $display("FAIL arb_rsp%0d: got valid=%b prodt=%h required %b %h", n, rv, prod, got, e.prod);
            else passes++;
            ack(w);
        end
        req_valid = '0;
        @(negedge clock);
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        logic [NREQ-1:0] rv;
        logic [NREQ-1:0] got;
        logic [63:0] prod;
        exp_t e;
        request(2, 32'd123456, -32'sd789, ok);
        req_mlier[31:0] = 32'd11;
        req_mcand[31:0] = 32'd13;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b1;
        await_rsp(cyc, rv, prod);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (rsp_valid !== rv || rsp_prodt !== prod || busy !== 1'b1 || req_ready !== '0 || rv !== 4'b0100)
                $display("FAIL stall_hold%0d: got valid=%b prodt=%h busy=%b ready=%b required 0100 %h 1 0000",
                         i, rsp_valid, rsp_prodt, busy, req_ready, prod);
            else passes++;
        end
        rsp_ready[0] = 1'b0;
        e = pop_exp();
        checks++;
        if (!ok || prod !== e.prod) $display("FAIL stall_prodt: got %h required %h", prod, e.prod);
        else passes++;
        ack(2);
        got = '0;
        for (int t = 0; t < 50 && got === '0; t++) begin
            @(negedge clock);
            got = req_ready;
        end
        req_valid[0] = 1'b0;
        checks++;
        if (got !== 4'b0001) $display("FAIL stall_next_grant: got %b required 0001", got);
        else passes++;
        await_rsp(cyc, rv, prod);
        checks++;
        if (cyc !== 35 || prod !== 64'd143) $display("FAIL stall_next_rsp: got lat=%0d prodt=%h required 35 8f", cyc, prod);
        else passes++;
        ack(0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        logic [NREQ-1:0] rv;
        logic [63:0] prod;
        exp_t e;
        request(1, 32'd1000, 32'd2000, ok);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({req_ready, rsp_valid, busy, m_start, m_mlier, m_mcand, rsp_prodt} !== '0)
            $display("FAIL midreset_outputs: got busy=%b start=%b ops=%h prodt=%h required all 0",
                     busy, m_start, {m_mlier, m_mcand}, rsp_prodt);
        else passes++;
        sb.delete();
        reset = 1'b0;
        @(negedge clock);
        request(3, -32'sd77777, 32'd31, ok);
        await_rsp(cyc, rv, prod);
        e = pop_exp();
        checks++;
        if (!ok || cyc !== 35 || rv !== 4'b1000 || prod !== e.prod)
            $display("FAIL midreset_recover: got lat=%0d valid=%b prodt=%h required 35 1000 %h", cyc, rv, prod, e.prod);
        else passes++;
        ack(3);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        int idx;
        int gap0;
        logic [31:0] a;
        logic [31:0] b;
        logic [NREQ-1:0] rv;
        logic [63:0] prod;
        exp_t e;
        gap0 = gap_bad;
        for (int n = 0; n < 8; n++) begin
            idx = $urandom_range(0, NREQ - 1);
            a = $urandom;
            b = $urandom;
            if (n == 0) begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
            if (n == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            request(idx, a, b, ok);
            await_rsp(cyc, rv, prod);
            e = pop_exp();
            checks++;
            if (!ok || cyc !== 35 || rv !== onehot(idx) || prod !== e.prod)
                $display("FAIL b2b_op%0d: got lat=%0d valid=%b prodt=%h required 35 %b %h",
                         n, cyc, rv, prod, onehot(idx), e.prod);
            else passes++;
            ack(idx);
            checks++;
            if (last_hi !== 35) $display("FAIL b2b_start_len%0d: got %0d required 35", n, last_hi);
            else passes++;
        end
        checks++;
        if (gap_bad !== gap0) $display("FAIL b2b_start_gap: got %0d short gaps required 0", gap_bad - gap0);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_arbitration();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
